// File: rtl/lidar_scan_ctrl.sv
// LiDAR scan session controller: start/stop command bytes over UART TX, frame
// watchdog with bounded start retries, and per-bit obstacle debounce filter.
module lidar_scan_ctrl #(
  parameter logic [7:0]  CMD_HDR        = 8'hA5,
  parameter logic [7:0]  CMD_START      = 8'h60,
  parameter logic [7:0]  CMD_STOP       = 8'h65,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned FILTER_N       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [7:0]  tx_data,
  output logic        tx_dv,
  input  logic        tx_done,
  input  logic        frame_dv,
  input  logic [7:0]  frame_ct,
  input  logic [15:0] frame_obs,
  output logic [15:0] obs_stable,
  output logic        obs_valid,
  output logic [15:0] frame_count,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TIMER_W = ($clog2(TIMEOUT_CYCLES) > 20) ? $clog2(TIMEOUT_CYCLES) : 20;
  localparam int unsigned RETRY_W = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned OBS_W   = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TX_B0      = 3'd1,
    TX_B1      = 3'd2,
    WAIT_FRAME = 3'd3,
    FAULT      = 3'd4,
    STOP_B0    = 3'd5,
    STOP_B1    = 3'd6
  } state_t;

  state_t                       state_q, state_d;
  logic [TIMER_W-1:0]           timer_q, timer_d;
  logic [RETRY_W-1:0]           retries_q, retries_d, retry_inc;
  logic                         stop_req_q, stop_req_d;
  logic [OBS_W-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [OBS_W-1:0]             stable_d;
  logic [7:0]                   tx_data_d;
  logic                         tx_dv_d;
  logic                         fault_d;
  logic [15:0]                  frame_count_d;
  logic                         frame_acc;
  logic                         enter_idle;

  assign retry_inc = retries_q + RETRY_W'(1);
  assign state_dbg = state_q;

  // Next state, watchdog/retry bookkeeping and registered-output next values
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retries_d     = retries_q;
    stop_req_d    = stop_req_q;
    frame_acc     = 1'b0;
    enter_idle    = 1'b0;
    tx_dv_d       = 1'b0;
    tx_data_d     = tx_data;
    fault_d       = fault;
    frame_count_d = frame_count;

    unique case (state_q)
      IDLE: if (en) state_d = TX_B0;
      TX_B0: begin
        if (!en) stop_req_d = 1'b1;
        if (tx_done) state_d = TX_B1;
      end
      TX_B1: begin
        // A stop request seen during the start command is honoured once it completes
        if (tx_done) begin
          state_d    = (stop_req_q || !en) ? STOP_B0 : WAIT_FRAME;
          stop_req_d = 1'b0;
        end else if (!en) begin
          stop_req_d = 1'b1;
        end
      end
      WAIT_FRAME: begin
        timer_d = timer_q + TIMER_W'(1);
        if (frame_dv) begin
          timer_d   = '0;
          retries_d = '0;
          frame_acc = (frame_ct != 8'd0);
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          retries_d = retry_inc;
          state_d   = (retry_inc <= RETRY_W'(MAX_RETRIES)) ? TX_B0 : FAULT;
        end
        if (!en) state_d = STOP_B0;
      end
      FAULT:   if (!en) state_d = STOP_B0;
      STOP_B0: if (tx_done) state_d = STOP_B1;
      STOP_B1: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == WAIT_FRAME && state_q != WAIT_FRAME) timer_d = '0;

    enter_idle = (state_d == IDLE) && (state_q != IDLE);
    if (enter_idle) begin
      retries_d  = '0;
      stop_req_d = 1'b0;
      fault_d    = 1'b0;
    end
    if (state_d == FAULT) fault_d = 1'b1;

    // One send request on entry to each command-byte state
    if (state_d != state_q) begin
      unique case (state_d)
        TX_B0, STOP_B0: begin tx_dv_d = 1'b1; tx_data_d = CMD_HDR;   end
        TX_B1:          begin tx_dv_d = 1'b1; tx_data_d = CMD_START; end
        STOP_B1:        begin tx_dv_d = 1'b1; tx_data_d = CMD_STOP;  end
        default:        ;
      endcase
    end

    if (frame_acc) frame_count_d = frame_count + 16'd1;
  end

  // Per-bit saturating debounce counters
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = obs_stable;
    if (frame_acc) begin
      for (int i = 0; i < OBS_W; i++) begin
        if (frame_obs[i])
          cnt_d[i] = (cnt_q[i] >= CNT_W'(FILTER_N)) ? CNT_W'(FILTER_N) : cnt_q[i] + CNT_W'(1);
        else
          cnt_d[i] = '0;
        stable_d[i] = (cnt_d[i] == CNT_W'(FILTER_N));
      end
    end
    if (enter_idle) begin
      cnt_d    = '0;
      stable_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retries_q   <= '0;
      stop_req_q  <= 1'b0;
      cnt_q       <= '0;
      obs_stable  <= '0;
      obs_valid   <= 1'b0;
      frame_count <= '0;
      fault       <= 1'b0;
      tx_dv       <= 1'b0;
      tx_data     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retries_q   <= retries_d;
      stop_req_q  <= stop_req_d;
      cnt_q       <= cnt_d;
      obs_stable  <= stable_d;
      obs_valid   <= frame_acc;
      frame_count <= frame_count_d;
      fault       <= fault_d;
      tx_dv       <= tx_dv_d;
      tx_data     <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_lidar_scan_ctrl.sv
// Directed bench for lidar_scan_ctrl: command sequencing, debounce table,
// watchdog retry/fault, timeout tie and reset during a stop command.
module tb_lidar_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, en, tx_done, frame_dv;
  logic [7:0]  tx_data, frame_ct;
  logic        tx_dv, obs_valid, fault;
  logic [15:0] frame_obs, obs_stable, frame_count;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx_log[$];
  int         dv_count = 0;
  int         vcount   = 0;
  logic       auto_done = 1'b1;

  typedef struct {
    logic [7:0]  ct;
    logic [15:0] obs;
    logic [15:0] exp_stable;
    logic        exp_valid;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [9];

  lidar_scan_ctrl #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES(2),
    .FILTER_N(3)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .tx_data(tx_data), .tx_dv(tx_dv), .tx_done(tx_done),
    .frame_dv(frame_dv), .frame_ct(frame_ct), .frame_obs(frame_obs),
    .obs_stable(obs_stable), .obs_valid(obs_valid), .frame_count(frame_count),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // UART TX model: logs each byte, answers with tx_done three cycles later
  initial begin
    int cd;
    cd = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
      if (tx_dv) begin
        tx_log.push_back(tx_data);
        dv_count++;
        if (auto_done) cd = 3;
      end
      if (obs_valid) vcount++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state_dbg != s && n < budget) begin tick(); n++; end
    check($sformatf("wait_state_%0d", s), 32'(state_dbg), 32'(s));
  endtask

  task automatic measure_wait(output int n);
    n = 0;
    while (state_dbg == 3'd3 && n < 1000) begin tick(); n++; end
  endtask

  task automatic pulse_frame(input logic [7:0] ct, input logic [15:0] obs);
    frame_ct = ct; frame_obs = obs; frame_dv = 1'b1;
    tick();
    frame_dv = 1'b0;
  endtask

  function automatic logic [31:0] log_word();
    logic [31:0] w;
    w = '0;
    foreach (tx_log[i]) w = {w[23:0], tx_log[i]};
    return w;
  endfunction

  initial begin
    int gap, dv_snap;
    logic seen3;

    vecs[0] = '{8'd10, 16'h0005, 16'h0000, 1'b1, 16'd1};
    vecs[1] = '{8'd10, 16'h0005, 16'h0000, 1'b1, 16'd2};
    vecs[2] = '{8'd10, 16'h0005, 16'h0005, 1'b1, 16'd3};
    vecs[3] = '{8'd10, 16'h0001, 16'h0001, 1'b1, 16'd4};
    vecs[4] = '{8'd0,  16'hFFFF, 16'h0001, 1'b0, 16'd4};
    vecs[5] = '{8'd5,  16'h8001, 16'h0001, 1'b1, 16'd5};
    vecs[6] = '{8'd5,  16'h8001, 16'h0001, 1'b1, 16'd6};
    vecs[7] = '{8'd5,  16'h8000, 16'h8000, 1'b1, 16'd7};
    vecs[8] = '{8'd1,  16'h0000, 16'h0000, 1'b1, 16'd8};

    reset = 1'b1; en = 1'b0; frame_dv = 1'b0; frame_ct = '0; frame_obs = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx_dv", 32'(tx_dv), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_stable", 32'(obs_stable), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_fault_state", {fault, state_dbg}, 0);

    // Start sequence, with a stray frame during TX_B1
    en = 1'b1;
    wait_state(3'd2, 50);
    pulse_frame(8'd10, 16'hFFFF);
    wait_state(3'd3, 50);
    tick();
    check("start_bytes", log_word(), 32'h0000A560);
    check("start_dv_count", dv_count, 2);
    check("txb1_frame_ignored", 32'(frame_count), 0);
    check("txb1_no_valid", vcount, 0);

    // Debounce table
    foreach (vecs[i]) begin
      pulse_frame(vecs[i].ct, vecs[i].obs);
      check($sformatf("vec%0d_valid", i), 32'(obs_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_stable", i), 32'(obs_stable), 32'(vecs[i].exp_stable));
      check($sformatf("vec%0d_count", i), 32'(frame_count), 32'(vecs[i].exp_count));
      tick(); tick();
    end
    check("table_valid_pulses", vcount, 8);

    // Zero-sample frame still feeds the watchdog
    dv_snap = dv_count;
    repeat (90) tick();
    pulse_frame(8'd0, 16'hFFFF);
    repeat (90) tick();
    check("ct0_state", 32'(state_dbg), 3);
    check("ct0_no_retry", dv_count, dv_snap);
    check("ct0_count", 32'(frame_count), 8);
    check("ct0_no_valid", vcount, 8);

    // First timeout: re-issue start
    tx_log.delete();
    wait_state(3'd1, 200);
    wait_state(3'd3, 50);
    tick();
    check("retry1_bytes", log_word(), 32'h0000A560);

    // Frame exactly on the expiry cycle wins and clears the retry count
    wait_state(3'd3, 5);
    repeat (98) tick();
    dv_snap = dv_count;
    pulse_frame(8'd7, 16'h0000);
    check("tie_state", 32'(state_dbg), 3);
    check("tie_count", 32'(frame_count), 9);
    check("tie_valid", 32'(obs_valid), 1);

    // With retries reset, two full re-issues then FAULT
    tx_log.delete();
    measure_wait(gap);
    check("gap1", gap, 100);
    wait_state(3'd3, 50);
    measure_wait(gap);
    check("gap2", gap, 100);
    wait_state(3'd3, 50);
    measure_wait(gap);
    check("gap3", gap, 100);
    check("fault_state", 32'(state_dbg), 4);
    check("fault_flag", 32'(fault), 1);
    check("retry_bytes_n", tx_log.size(), 4);
    check("retry_bytes", log_word(), 32'hA560A560);
    pulse_frame(8'd3, 16'hFFFF);
    tick();
    check("fault_frame_ignored", 32'(frame_count), 9);
    check("fault_hold", {fault, state_dbg}, 32'h0C);

    // Stop from FAULT
    tx_log.delete();
    en = 1'b0;
    wait_state(3'd0, 60);
    tick();
    check("stop_bytes", log_word(), 32'h0000A565);
    check("stop_fault_clr", 32'(fault), 0);

    // en dropped during TX_B0: start completes, then straight to stop
    tx_log.delete();
    en = 1'b1;
    wait_state(3'd1, 10);
    en = 1'b0;
    seen3 = 1'b0;
    for (int n = 0; n < 80 && state_dbg != 3'd0; n++) begin
      tick();
      if (state_dbg == 3'd3) seen3 = 1'b1;
    end
    tick();
    check("abort_no_wait", 32'(seen3), 0);
    check("abort_bytes", log_word(), 32'hA560A565);

    // Reset between STOP_B0's request and its completion
    en = 1'b1;
    wait_state(3'd3, 50);
    pulse_frame(8'd2, 16'h0003);
    auto_done = 1'b0;
    en = 1'b0;
    wait_state(3'd5, 5);
    check("stop_b0_entry", {tx_dv, tx_data}, 32'h1A5);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_tx", {tx_dv, tx_data}, 0);
    check("mid_rst_state", {fault, state_dbg}, 0);
    check("mid_rst_count", 32'(frame_count), 0);
    reset = 1'b0;
    dv_snap = dv_count;
    repeat (20) tick();
    check("mid_rst_no_dv", dv_count, dv_snap);
    check("mid_rst_idle", 32'(state_dbg), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lidar_scan_ctrl.md
Name: lidar_scan_ctrl

Overview:
- Sequences the LiDAR scan session and sits between the UART TX path and the scan-packet parser.
- Sends start/stop command bytes to the sensor through a UART TX handshake.
- Watches the parser's frame-done pulse with a watchdog and retries or faults on a silent sensor.
- Debounces the per-frame 16-bit obstacle bitmap over consecutive frames into a stable bitmap for the motion controller.

Parameters:
- CMD_HDR, 8'hA5, first byte of every command.
- CMD_START, 8'h60, second byte of the start-scan command.
- CMD_STOP, 8'h65, second byte of the stop-scan command.
- TIMEOUT_CYCLES, 1000000, cycles without a frame before a retry; minimum 2.
- MAX_RETRIES, 3, number of start re-issues before the block enters FAULT; range 1..15.
- FILTER_N, 3, consecutive frames a bit must be set before it is declared stable; range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  level; high requests scanning.
- tx_data  out  8  command byte, valid while tx_dv is high.
- tx_dv  out  1  one-cycle byte-send request to the UART TX.
- tx_done  in  1  one-cycle pulse from the UART TX: byte fully sent.
- frame_dv  in  1  one-cycle pulse from the parser: frame complete.
- frame_ct  in  8  sample count of the completed frame; valid with frame_dv.
- frame_obs  in  16  per-frame obstacle bitmap; valid with frame_dv.
- obs_stable  out  16  debounced obstacle bitmap.
- obs_valid  out  1  one-cycle pulse when obs_stable has been updated.
- frame_count  out  16  accepted frames, wraps at 16'hFFFF to 0.
- fault  out  1  sensor silent after all retries.
- state_dbg  out  3  current state encoding.

Behaviour:
Reset values:
- All outputs 0: tx_dv=0, tx_data=0, obs_stable=0, obs_valid=0, frame_count=0, fault=0, state_dbg=IDLE.
- Filter counters, retry counter and timer are 0.
- Reset asserted mid-operation aborts everything on the next edge. tx_dv is low from that edge on, and no stop command is sent.

States and encodings: IDLE=0, TX_B0=1, TX_B1=2, WAIT_FRAME=3, FAULT=4, STOP_B0=5, STOP_B1=6.

Command byte sequencing:
- Every TX_* and STOP_* state issues exactly one byte.
- Entry cycle: tx_dv=1 for exactly one cycle, with tx_data set to the byte.
- The state then holds with tx_dv=0 until tx_done, then advances on the next edge.
- A second tx_dv is never issued before tx_done for the previous byte.

Transitions:
- IDLE: en=1 → TX_B0 (CMD_HDR) → TX_B1 (CMD_START) → WAIT_FRAME.
- Entering WAIT_FRAME clears the timer.
- WAIT_FRAME, frame_dv=1:
  - Clears the timer and the retry counter.
  - If frame_ct != 0: updates the filter, increments frame_count, and pulses obs_valid on the following cycle.
  - If frame_ct == 0: only the timer and retries are cleared. No filter update, no count, no obs_valid.
- WAIT_FRAME, timer reaches TIMEOUT_CYCLES-1 with no frame_dv:
  - Increments retries.
  - If retries(new) <= MAX_RETRIES → TX_B0 (re-issue start).
  - Otherwise → FAULT with fault=1.
- frame_dv in the same cycle as timeout expiry: the frame wins and no retry occurs.
- WAIT_FRAME, en=0 → STOP_B0 (CMD_HDR) → STOP_B1 (CMD_STOP) → IDLE.
- en=0 during TX_B0/TX_B1: the start command completes (both bytes), then the block goes directly to STOP_B0 without entering WAIT_FRAME.
- FAULT: holds fault=1 and ignores frame_dv; en=0 → STOP_B0. fault clears when entering IDLE.
- en=1 during STOP_*: the stop completes, then IDLE, then a restart on the next cycle.
- frame_dv outside WAIT_FRAME is ignored completely.

Filter (per bit i, 3-bit saturating counter c[i]):
- On an accepted frame with frame_obs[i]=1: c[i] <= min(c[i]+1, FILTER_N).
- On an accepted frame with frame_obs[i]=0: c[i] <= 0.
- obs_stable[i] is updated in the same edge: 1 iff the new c[i]==FILTER_N. A set bit therefore clears immediately on a clear frame.
- Entering IDLE clears all counters and obs_stable.

Timer: a 20-bit or wider counter that does not wrap before TIMEOUT_CYCLES.

Test Plan:
- Start sequence: reset, en=1, bench answers each tx_dv with tx_done 3 cycles later. Expect tx_data A5 then 60, exactly 2 tx_dv pulses, state_dbg=3.
- Debounce: three frames with frame_obs=16'h0005, then one with 16'h0001, FILTER_N=3. Expect obs_stable 0, 0, 5, then 1; 4 obs_valid pulses; frame_count=4.
- Retry and fault: TIMEOUT_CYCLES=100, MAX_RETRIES=2, no frames. Expect 2 start re-issues (A5,60 each) at 100-cycle gaps after each start completes, then fault=1, state_dbg=4. Then en=0: expect A5,65 sent, fault=0, IDLE.
- Timeout tie: frame_dv exactly on cycle TIMEOUT_CYCLES-1. Expect no re-issue, retries=0, frame accepted.
- Edge frames: frame_ct=0 frame resets the timer but frame_count is unchanged and there is no obs_valid. frame_dv while in TX_B1 is ignored.
- Reset mid-stop: assert reset between STOP_B0's tx_dv and its tx_done. Expect all outputs 0 on the next edge and no further tx_dv.
